// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: instruction-fetch front end feeding the F pipeline register.
// Owns the fetch PC, issues one instruction-memory read at a time and presents
// {pc_o, inst_o, valid_o} to F, holding under stall and squashing on redirect.
// Optional feature macro: FETCH_EBREAK_HALT_EN (stop fetching after EBREAK).
//
// Memory handshake: imem_req_o/imem_addr_o describe the read currently wanted.
// The memory may raise imem_ack_i (with imem_data_i) for the presented address
// at the end of any cycle in which imem_req_o=1, earliest in the first such
// cycle. If an edge sees imem_req_o=1 without an ack, the memory has committed
// to that read and will ack it later even if imem_req_o drops (redirect). Only
// one read is ever outstanding; an ack is accepted only while a read is
// requested or committed.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic        halted_o
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        drop_q, drop_d;
    logic        pend_q, pend_d;
    logic        halted_q, halted_d;

    logic        ack_v;
    logic        take;
    logic        consume;
    logic        is_ebreak;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = redirect_pc_i & 32'hFFFF_FFFC;
    assign ack_v        = imem_ack_i && (pend_q || imem_req_o);
    assign take         = ack_v && !drop_q && !redirect_i && (state_q == ST_REQ);
    assign consume      = valid_q && !stall_i;

`ifdef FETCH_EBREAK_HALT_EN
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
    assign is_ebreak = (imem_data_i == EBREAK_INST);
`else
    assign is_ebreak = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_REQ;
        else          state_q <= state_d;
    end

    // FSM next state: redirect always restarts fetching
    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            state_d = ST_REQ;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (take) begin
                        if (is_ebreak)    state_d = ST_HALT;
                        else if (stall_i) state_d = ST_HOLD;
                        else              state_d = ST_REQ;
                    end
                end
                ST_HOLD: if (!stall_i) state_d = ST_REQ;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_REQ;
            endcase
        end
    end

    // FSM outputs: request only when the output slot can accept a new beat
    always_comb begin
        imem_req_o  = rst_n_i && (state_q == ST_REQ) && !(valid_q && stall_i) && !redirect_i;
        imem_addr_o = fetch_pc_q;
        pc_o        = pc_q;
        inst_o      = inst_q;
        valid_o     = valid_q;
        halted_o    = halted_q;
    end

    // Datapath next values: consume, refill, drop stale acks, redirect
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = valid_q;
        drop_d     = drop_q;
        halted_d   = halted_q;
        pend_d     = ack_v ? 1'b0 : (pend_q || imem_req_o);
        if (redirect_i) begin
            fetch_pc_d = redirect_tgt;
            valid_d    = 1'b0;
            inst_d     = NOP_INST;
            halted_d   = 1'b0;
            // a committed read not answered on this edge still owes an ack
            drop_d     = pend_q && !ack_v;
        end else begin
            if (consume) valid_d = 1'b0;
            if (ack_v && drop_q) begin
                drop_d = 1'b0;
            end else if (take) begin
                pc_d       = fetch_pc_q;
                inst_d     = imem_data_i;
                valid_d    = 1'b1;
                fetch_pc_d = fetch_pc_q + PC_STEP;
                if (is_ebreak) halted_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc_q <= RESET_PC;
            pc_q       <= 32'h0000_0000;
            inst_q     <= NOP_INST;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
            pend_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
            pend_q     <= pend_d;
            halted_q   <= halted_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: bench for fetch_pc_gen. A memory model answers reads with a
// chosen latency; a fetch-stream model predicts the sequence of delivered
// (pc, inst) beats into exp_q; a monitor pops one entry per consumed beat.
module tb_fetch_pc_gen;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'h0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;
    logic        halted_o;

    fetch_pc_gen dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .valid_o      (valid_o),
        .halted_o     (halted_o)
    );

    // clock
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic        run = 1'b0;

    // fetch-stream model
    logic [31:0] exp_pc = 32'h0;
    logic        exp_halted = 1'b0;
    logic        halted_nxt = 1'b0;

    // memory model
    logic        mem_busy = 1'b0;
    logic        mem_stale = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return EBREAK;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // one clock cycle: drive inputs at negedge, answer memory, step the model
    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input int lat);
        logic started;
        @(negedge clk);
        exp_halted    = halted_nxt;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_ack_i    = 1'b0;
        #1;
        started = 1'b0;
        if (mem_busy) begin
            if (mem_cnt > 0) mem_cnt--;
        end else if (imem_req_o) begin
            mem_busy  = 1'b1;
            mem_addr  = imem_addr_o;
            mem_cnt   = lat - 1;
            mem_stale = 1'b0;
            started   = 1'b1;
        end
        if (mem_busy && imem_req_o && !mem_stale && !started)
            check("addr_stable", imem_addr_o, mem_addr);
        imem_ack_i  = mem_busy && (mem_cnt == 0);
        imem_data_i = imem_ack_i ? mem_word(mem_addr) : $urandom;
        if (imem_ack_i) begin
            if (!mem_stale && !rd) begin
                check("fetch_addr", mem_addr, exp_pc);
                exp_q.push_back({exp_pc, mem_word(exp_pc)});
`ifdef FETCH_EBREAK_HALT_EN
                if (mem_word(exp_pc) == EBREAK) halted_nxt = 1'b1;
`endif
                exp_pc = exp_pc + 32'd4;
            end
            mem_busy = 1'b0;
        end
        if (rd) begin
            if (st) exp_q.delete();
            exp_pc     = rpc & 32'hFFFF_FFFC;
            halted_nxt = 1'b0;
            if (mem_busy) mem_stale = 1'b1;
        end
    endtask

    // monitor: compare every beat F captures against the scoreboard
    logic [63:0] mon_e;
    always @(negedge clk) begin
        #2;
        if (rst_n && run) begin
            check("halted", {31'b0, halted_o}, {31'b0, exp_halted});
            if (exp_halted) check("halt_no_req", {31'b0, imem_req_o}, 32'd0);
            if (valid_o && !stall_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got pc %h, expected no beat", pc_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_pc", pc_o, mon_e[63:32]);
                    check("beat_inst", inst_o, mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        // reset
        #12;
        check("rst_pc", pc_o, 32'h0);
        check("rst_inst", inst_o, NOP);
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_halted", {31'b0, halted_o}, 32'd0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        run = 1'b1;

        // streaming at one beat per cycle
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1);
        // stall while pc 8 is presented
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1);
            check("stall_pc", pc_o, 32'h8);
            check("stall_valid", {31'b0, valid_o}, 32'd1);
            check("stall_req", {31'b0, imem_req_o}, 32'd0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1);
`ifdef FETCH_EBREAK_HALT_EN
        check("ebreak_halted", {31'b0, halted_o}, 32'd1);
        check("ebreak_req", {31'b0, imem_req_o}, 32'd0);
`endif
        // redirect to 0x40 (resumes from halt when enabled)
        cycle(1'b0, 1'b1, 32'h40, 1);
        cycle(1'b0, 1'b0, 32'h0, 3);
        check("resume_addr", imem_addr_o, 32'h40);
        check("resume_halted", {31'b0, halted_o}, 32'd0);

        // redirect to 0x103 while a read is committed, its ack arrives later
        cycle(1'b0, 1'b1, 32'h0000_0103, 3);
        cycle(1'b0, 1'b0, 32'h0, 3);
        check("redir_addr", imem_addr_o, 32'h100);
        check("redir_valid", {31'b0, valid_o}, 32'd0);
        check("redir_inst", inst_o, NOP);
        cycle(1'b0, 1'b0, 32'h0, 2);
        check("redir_wait_valid", {31'b0, valid_o}, 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 2);
        cycle(1'b0, 1'b0, 32'h0, 2);
        check("redir_first_pc", pc_o, 32'h100);

        // long ack latency
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 32'h0, 5);

        // address wrap at the top of the space, low target bits ignored
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1);
            if (exp_pc == 32'h0) break;
        end
        cycle(1'b0, 1'b0, 32'h0, 1);
        check("wrap_addr", imem_addr_o, 32'h0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = $urandom;
                1:       rpc = $urandom_range(0, 255);
                2:       rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: rpc = 32'h0000_0008;
            endcase
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, rpc, $urandom_range(1, 4));
        end

        // flush: stalled redirect squashes any presented beat
        cycle(1'b1, 1'b1, 32'h0, 1);
        @(posedge clk);
        #2;
        check("drain_valid", {31'b0, valid_o}, 32'd0);
        check("drain_queue", exp_q.size(), 32'd0);
        run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
